ula_muldiv: RTL
===============

// Module: ula_muldiv
// PURPOSE
//   Iterative multi-cycle multiply/divide/remainder unit alongside ula. It takes over the
//   combinational mul/div/rem paths (ULActl 0100/0101/1001), which are too slow for timing.
//   Consumes the same A/B operand buses; its result is muxed into the ULAout/writeback path.
//   The control unit stalls on busy and samples result when done pulses.
// PARAMETERS
//   WIDTH   32   operand/result width; latency scales with WIDTH (any WIDTH >= 2)
// PORTS
//   clock   in   1      single clock, all state updates on rising edge
//   reset   in   1      synchronous, active-high
//   start   in   1      request; sampled only in IDLE or DONE
//   op      in   2      00 MUL, 01 DIV, 10 REM, 11 reserved
//   A       in   WIDTH  operand A (multiplicand / dividend), unsigned
//   B       in   WIDTH  operand B (multiplier / divisor), unsigned
//   result  out  WIDTH  registered result, held until next accepted start
//   zero    out  1      result == 0 (same meaning as ula zero)
//   busy    out  1      high while computing
//   done    out  1      one-cycle pulse: result valid
// BEHAVIOUR
//   - Reset (sync, active-high): state IDLE, result=0, busy=0, done=0, count=0, op latch=00.
//     Reset mid-operation aborts; no done pulse, result forced to 0.
//   - FSM: IDLE -> RUN on start; RUN -> DONE after WIDTH iterations; DONE -> IDLE if !start,
//     DONE -> RUN if start (back-to-back accepted). start in RUN is ignored, not queued.
//   - Accept edge: latch op, A, B into internal regs; count=0; busy=1 from next cycle.
//     A/B may change after acceptance without effect.
//   - RUN: one iteration per clock, count increments; on iteration WIDTH (count==WIDTH-1):
//     result written, state DONE, busy=0, done=1 for exactly one cycle.
//   - Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH
//     (32 iterations for WIDTH=32). Fixed for all ops and operand values.
//   - MUL: shift-add, unsigned; result = low WIDTH bits of A*B (matches ula truncation).
//   - DIV/REM: restoring division, unsigned, 1 quotient bit per cycle MSB first.
//     Result = quotient (DIV) or remainder (REM).
//   - Divide by zero (B==0): no trap, normal latency.
//     DIV -> all ones ({WIDTH{1'b1}}); REM -> A.
//     These fall naturally out of the restoring algorithm.
//   - op 11: runs full latency, result = 0.
//   - result and zero change only on the DONE-entry edge or reset; stable otherwise.
//   - Internal accumulators are 2*WIDTH (MUL) and WIDTH+1 (DIV) bits; no overflow flag.
// TESTING
//   1. MUL A=7, B=6, start 1 cycle -> busy 32 cycles, done pulse 1 cycle, result=42, zero=0.
//   2. MUL A=32'hFFFF_FFFF, B=2 -> result=32'hFFFF_FFFE (truncated).
//      DIV A=100, B=7 -> 14; REM A=100, B=7 -> 2.
//   3. DIV A=5, B=0 -> 32'hFFFF_FFFF; REM A=5, B=0 -> 5; both at 32-cycle latency.
//      REM A=6, B=3 -> result=0, zero=1.
//   4. start pulsed again at cycles 5 and 20 of a MUL 3*4 -> ignored, result=12.
//      Assert done exactly once and A/B changes after accept have no effect.
//   5. start held high through DONE with new op DIV 9/3 -> back-to-back accept.
//      Second done 33 cycles after first; results 12 then 3.
//   6. reset asserted at iteration 10 of DIV -> next cycle IDLE, busy=0, result=0, no done.
//      Then a new MUL 2*3 completes normally = 6.

Source files
------------

// File: rtl/ula_muldiv.sv
// Iterative unsigned multiply / divide / remainder unit: one shift-add or
// restoring-division step per clock, fixed WIDTH-cycle latency for every op.
module ula_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_REM = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // Multiply datapath: multiplicand shifts left, multiplier shifts right.
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    // Divide datapath: dividend bits leave quot_q MSB first while quotient
    // bits enter at the LSB.
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;

    logic               accept;
    logic               last_iter;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quot_step;

    always_comb begin
        accept    = start && (state_q != S_RUN);
        last_iter = (state_q == S_RUN) && (count_q == LAST);

        prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

        // Partial remainder is held in WIDTH+1 bits for the compare; after a
        // successful subtract it always fits in WIDTH bits again.
        rem_shift = {rem_q, quot_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, divisor_q});
        rem_step  = rem_ge ? (rem_shift[WIDTH-1:0] - divisor_q) : rem_shift[WIDTH-1:0];
        quot_step = {quot_q[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        result_d  = result_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        mplier_d  = mplier_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_RUN;
            end
            S_RUN: begin
                count_d  = count_q + 1'b1;
                prod_d   = prod_step;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                quot_d   = quot_step;
                rem_d    = rem_step;
                if (last_iter) begin
                    state_d = S_DONE;
                    case (op_q)
                        OP_MUL:  result_d = prod_step[WIDTH-1:0];
                        OP_DIV:  result_d = quot_step;
                        OP_REM:  result_d = rem_step;
                        default: result_d = '0;
                    endcase
                end
            end
            S_DONE: begin
                state_d = accept ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            count_d   = '0;
            op_d      = op;
            mcand_d   = {{WIDTH{1'b0}}, A};
            prod_d    = '0;
            mplier_d  = B;
            quot_d    = A;
            rem_d     = '0;
            divisor_d = B;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            op_q      <= 2'b00;
            result_q  <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            result_q  <= result_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            mplier_q  <= mplier_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
        end
    end

    assign result = result_q;
    assign zero   = (result_q == '0);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);

endmodule
